// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the exponent scanner slice.
//   scan_state_t       : control states of exponent_scanner
//   DEFAULT_WORD_WIDTH : default width of the exponent load bus
//   ceil_div           : integer ceiling division for derived word counts
// ---------------------------------------------------------------------------
package rsa_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SCAN  = 2'd2,
    READY = 2'd3
  } scan_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/msb_encoder.sv
// ---------------------------------------------------------------------------
// msb_encoder
// Finds the index of the most-significant set bit of one word.
//   word    : input word (WORD_WIDTH bits)
//   msb_idx : index of the highest set bit, 0 when the word is zero
//   nonzero : 1 when any bit of word is set
// Purely combinational.
// ---------------------------------------------------------------------------
module msb_encoder
  import rsa_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int IDX_W      = $clog2(WORD_WIDTH)
) (
  input  logic [WORD_WIDTH-1:0] word,
  output logic [IDX_W-1:0]      msb_idx,
  output logic                  nonzero
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    msb_idx = '0;
    nonzero = 1'b0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (word[i]) begin
        msb_idx = IDX_W'(i);
        nonzero = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exponent_scanner.sv
// ---------------------------------------------------------------------------
// exponent_scanner
// Loads an exponent word by word, locates its most-significant set bit and
// then walks the exponent one bit per inc, presenting the current bit.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   ce                  : clock enable, all state holds while low
//   load_valid/ready    : word handshake, load_data LS word first,
//   load_data/last        load_last marks the final word
//   inc                 : advance to the next exponent bit (READY only)
//   clear               : abandon current exponent, return to IDLE
//   cnt                 : index of the current exponent bit
//   r_t_sub_1           : index of the most-significant set bit
//   r_d_0               : exponent bit cnt
//   scan_done           : r_t_sub_1 valid, exponent ready to iterate
//   exp_zero            : loaded exponent was all zeros
//   state_dbg           : current FSM state (scan_state_t encoding)
//
// Handshake: a word transfers on any rising edge where ce, load_valid and
// load_ready are all high. load_ready is decoded from the state register only
// (high in IDLE and LOAD), so it never depends on load_valid; load_valid
// presented while load_ready is low is ignored, never queued.
// ---------------------------------------------------------------------------
module exponent_scanner
  import rsa_pkg::*;
#(
  parameter int DATA_WIDTH = 1025,
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  load_valid,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  inc,
  input  logic                  clear,
  output logic [CNT_W-1:0]      cnt,
  output logic [CNT_W-1:0]      r_t_sub_1,
  output logic                  r_d_0,
  output logic                  scan_done,
  output logic                  exp_zero,
  output logic [1:0]            state_dbg
);

  localparam int NWORDS = ceil_div(DATA_WIDTH, WORD_WIDTH);
  localparam int PAD_W  = NWORDS * WORD_WIDTH;
  localparam int WIDX_W = $clog2(NWORDS + 1);
  localparam int MSB_W  = $clog2(WORD_WIDTH);

  // Bits at or above DATA_WIDTH are forced to zero so the padded top word
  // can never contribute to the msb search.
  localparam logic [PAD_W-1:0]  DATA_MASK = {PAD_W{1'b1}} >> (PAD_W - DATA_WIDTH);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NWORDS - 1);
  localparam logic [WIDX_W-1:0] NWORDS_V  = WIDX_W'(NWORDS);

  scan_state_t       state_q, state_d;
  logic [PAD_W-1:0]  exp_q, exp_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic [WIDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rts_q, rts_d;
  logic              r_d_0_q, r_d_0_d;
  logic              scan_done_q, scan_done_d;
  logic              exp_zero_q, exp_zero_d;

  logic [WORD_WIDTH-1:0] scan_word;
  logic [MSB_W-1:0]      scan_msb;
  logic                  scan_nonzero;
  logic [WIDX_W-1:0]     wr_idx;
  logic                  xfer;

  assign load_ready = (state_q == IDLE) || (state_q == LOAD);
  assign xfer       = load_valid & load_ready;
  // The first word of a new exponent always lands in word 0.
  assign wr_idx     = (state_q == IDLE) ? '0 : word_idx_q;
  assign scan_word  = exp_q[int'(scan_idx_q) * WORD_WIDTH +: WORD_WIDTH];

  msb_encoder #(
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_W      (MSB_W)
  ) u_msb (
    .word    (scan_word),
    .msb_idx (scan_msb),
    .nonzero (scan_nonzero)
  );

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    word_idx_d  = word_idx_q;
    scan_idx_d  = scan_idx_q;
    cnt_d       = cnt_q;
    rts_d       = rts_q;
    r_d_0_d     = r_d_0_q;
    scan_done_d = scan_done_q;
    exp_zero_d  = exp_zero_q;

    if (ce) begin
      if (clear) begin
        state_d     = IDLE;
        word_idx_d  = '0;
        cnt_d       = '0;
        rts_d       = '0;
        r_d_0_d     = 1'b0;
        scan_done_d = 1'b0;
        exp_zero_d  = 1'b0;
      end else if (xfer) begin
        if (state_q == IDLE) begin
          exp_d = '0;
        end
        // Words past the register are accepted but their data dropped.
        if (wr_idx < NWORDS_V) begin
          exp_d[int'(wr_idx) * WORD_WIDTH +: WORD_WIDTH] = load_data;
        end
        exp_d = exp_d & DATA_MASK;
        if (wr_idx != NWORDS_V) begin
          word_idx_d = wr_idx + 1'b1;
        end
        scan_idx_d = LAST_WORD;
        state_d    = load_last ? SCAN : LOAD;
      end else begin
        case (state_q)
          SCAN: begin
            if (scan_nonzero || (scan_idx_q == '0)) begin
              state_d     = READY;
              scan_done_d = 1'b1;
              exp_zero_d  = ~scan_nonzero;
              rts_d       = scan_nonzero
                            ? CNT_W'(int'(scan_idx_q) * WORD_WIDTH + int'(scan_msb))
                            : '0;
              cnt_d       = '0;
              r_d_0_d     = exp_q[0];
            end else begin
              scan_idx_d = scan_idx_q - 1'b1;
            end
          end
          READY: begin
            // Saturate at the msb index: inc there is ignored.
            if (inc && (cnt_q < rts_q)) begin
              cnt_d   = cnt_q + 1'b1;
              exp_d   = exp_q >> 1;
              r_d_0_d = exp_q[1];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      word_idx_q  <= '0;
      scan_idx_q  <= '0;
      cnt_q       <= '0;
      rts_q       <= '0;
      r_d_0_q     <= 1'b0;
      scan_done_q <= 1'b0;
      exp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      word_idx_q  <= word_idx_d;
      scan_idx_q  <= scan_idx_d;
      cnt_q       <= cnt_d;
      rts_q       <= rts_d;
      r_d_0_q     <= r_d_0_d;
      scan_done_q <= scan_done_d;
      exp_zero_q  <= exp_zero_d;
    end
  end

  assign cnt       = cnt_q;
  assign r_t_sub_1 = rts_q;
  assign r_d_0     = r_d_0_q;
  assign scan_done = scan_done_q;
  assign exp_zero  = exp_zero_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_exponent_scanner.sv
// ---------------------------------------------------------------------------
// tb_exponent_scanner
// Directed bench for exponent_scanner. Scan results are pushed to exp_q when
// a load is issued; a monitor pops and compares on each scan_done rise.
// Per-bit walking, saturation, clear, ce and reset behaviour are compared
// directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_exponent_scanner;
  import rsa_pkg::*;

  localparam int WW   = 32;
  localparam int CW   = 11;
  localparam int SB_W = 1 + CW + CW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          load_valid = 1'b0;
  logic [WW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          inc = 1'b0;
  logic          clear = 1'b0;
  logic          load_ready;
  logic [CW-1:0] cnt;
  logic [CW-1:0] r_t_sub_1;
  logic          r_d_0;
  logic          scan_done;
  logic          exp_zero;
  logic [1:0]    state_dbg;

  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] mon_e;
  logic            prev_done = 1'b0;
  int              checks = 0;
  int              failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  exponent_scanner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .inc        (inc),
    .clear      (clear),
    .cnt        (cnt),
    .r_t_sub_1  (r_t_sub_1),
    .r_d_0      (r_d_0),
    .scan_done  (scan_done),
    .exp_zero   (exp_zero),
    .state_dbg  (state_dbg)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [SB_W-1:0] pack(input logic z, input logic [CW-1:0] r,
                                           input logic [CW-1:0] c, input logic d);
    return {z, r, c, d};
  endfunction

  task automatic check_outs(input string name, input int c, input int r, input logic d);
    check({name, "_cnt"}, cnt, c);
    check({name, "_rts"}, r_t_sub_1, r);
    check({name, "_rd0"}, r_d_0, d);
  endtask

  task automatic check_idle(input string name);
    check({name, "_state"}, state_dbg, 32'(IDLE));
    check({name, "_ready"}, load_ready, 1);
    check({name, "_outs"}, {cnt, r_t_sub_1, r_d_0, scan_done, exp_zero}, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WW-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_inc(input int n);
    inc = 1'b1;
    repeat (n) step();
    inc = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Bounded wait for scan_done, counted from the last transfer edge.
  task automatic wait_done(input string name, input int max_cycles);
    int n = 0;
    while (!scan_done && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (!scan_done) begin
      failures++;
      $display("FAIL %s_timeout actual=no_scan_done required=within_%0d_cycles", name, max_cycles);
    end
    step();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      if (scan_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_scan_done actual=r_t_sub_1_%0d required=no_result", r_t_sub_1);
        end else begin
          mon_e = exp_q.pop_front();
          check("scan_result", 32'({exp_zero, r_t_sub_1, cnt, r_d_0}), 32'(mon_e));
        end
      end
      prev_done <= scan_done;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    step();

    // Single word, bits 0 and 16.
    exp_q.push_back(pack(1'b0, 11'd16, 11'd0, 1'b1));
    send_word(32'h0001_0001, 1'b1);
    wait_done("w10001", 34);
    do_inc(1);
    check_outs("w10001_inc1", 1, 16, 1'b0);
    do_inc(15);
    check_outs("w10001_inc16", 16, 16, 1'b1);
    do_inc(2);
    check_outs("w10001_sat", 16, 16, 1'b1);
    do_clear();
    check_idle("clear1");

    // All-zero exponent.
    exp_q.push_back(pack(1'b1, 11'd0, 11'd0, 1'b0));
    send_word(32'h0, 1'b1);
    wait_done("zero", 34);
    check("zero_flag", exp_zero, 1);
    do_inc(2);
    check_outs("zero_inc", 0, 0, 1'b0);
    do_clear();

    // 33 words, only the top word set: bits above 1024 discarded.
    exp_q.push_back(pack(1'b0, 11'd1024, 11'd0, 1'b0));
    for (int k = 0; k < 33; k++) send_word((k == 32) ? 32'hFFFF_FFFF : 32'h0, (k == 32));
    wait_done("top", 34);
    do_clear();

    // 35 words: words 33/34 past the register are dropped.
    exp_q.push_back(pack(1'b0, 11'd35, 11'd0, 1'b0));
    for (int k = 0; k < 35; k++) begin
      send_word((k == 1) ? 32'h8 : ((k > 32) ? 32'hFFFF_FFFF : 32'h0), (k == 34));
    end
    wait_done("extra", 34);
    do_clear();

    // Two words, msb at 63; then a fresh single word must not see word 1.
    exp_q.push_back(pack(1'b0, 11'd63, 11'd0, 1'b0));
    send_word(32'h0, 1'b0);
    check("load_state", state_dbg, 32'(LOAD));
    send_word(32'h8000_0000, 1'b1);
    wait_done("two", 34);
    do_clear();
    exp_q.push_back(pack(1'b0, 11'd2, 11'd0, 1'b0));
    send_word(32'h4, 1'b1);
    wait_done("reload", 34);
    // load_valid in READY is ignored.
    load_valid = 1'b1; load_data = 32'hFFFF_FFFF; load_last = 1'b1;
    check("ready_no_accept", load_ready, 0);
    step(); step();
    load_valid = 1'b0; load_last = 1'b0;
    check("ready_hold_state", state_dbg, 32'(READY));
    check("ready_hold_rts", r_t_sub_1, 2);
    do_clear();

    // 0xB: msb 3, saturation, ce hold in READY.
    exp_q.push_back(pack(1'b0, 11'd3, 11'd0, 1'b1));
    send_word(32'hB, 1'b1);
    wait_done("b", 34);
    ce = 1'b0;
    do_inc(3);
    ce = 1'b1;
    check_outs("ce_hold_ready", 0, 3, 1'b1);
    do_inc(2);
    check_outs("b_inc2", 2, 3, 1'b0);
    do_inc(1);
    check_outs("b_inc3", 3, 3, 1'b1);
    do_inc(5);
    check_outs("b_sat", 3, 3, 1'b1);
    do_clear();
    check_idle("clear_b");

    // inc outside READY ignored.
    do_inc(2);
    check("idle_inc", cnt, 0);

    // ce low with load_valid for 4 cycles: nothing accepted.
    ce = 1'b0;
    load_valid = 1'b1; load_data = 32'h5; load_last = 1'b1;
    repeat (4) step();
    load_valid = 1'b0; load_last = 1'b0;
    ce = 1'b1;
    step();
    check_idle("ce_hold_idle");

    // clear beats a simultaneous transfer in LOAD.
    send_word(32'h1, 1'b0);
    clear = 1'b1; load_valid = 1'b1; load_data = 32'h3; load_last = 1'b1;
    step();
    clear = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    check_idle("clear_vs_load");

    // Reset mid-SCAN, with ce low, acts immediately.
    send_word(32'h1, 1'b1);
    repeat (3) step();
    check("scan_state", state_dbg, 32'(SCAN));
    check("scan_ready", load_ready, 0);
    ce = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle("rst_scan");
    step();
    rst_n = 1'b1;
    ce = 1'b1;
    step();

    // Reset mid-READY clears nonzero outputs.
    exp_q.push_back(pack(1'b0, 11'd3, 11'd0, 1'b1));
    send_word(32'hB, 1'b1);
    wait_done("b2", 34);
    do_inc(2);
    check("b2_cnt", cnt, 2);
    rst_n = 1'b0;
    #1;
    check_idle("rst_ready");
    step();
    rst_n = 1'b1;
    step();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
